reg_writeback_queue: RTL

//  Write-side initiator for the 32x32 register file: owns the RegWr/Rw/busW port.

---
 rtl/reg_writeback_queue.sv | 102 ++++++++++
 1 files changed

// File: rtl/reg_writeback_queue.sv
`default_nettype none
// ============================================================================
// Module   : reg_writeback_queue
// Brief    : In-order writeback FIFO merging ALU and load results onto the
//            register-file write port, with per-register pending bits.
// Revision : 1.0
// ============================================================================
module reg_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     alu_valid,
  input  logic [AW-1:0]            alu_rd,
  input  logic [DW-1:0]            alu_data,
  output logic                     alu_ready,
  input  logic                     mem_valid,
  input  logic [AW-1:0]            mem_rd,
  input  logic [DW-1:0]            mem_data,
  output logic                     mem_ready,
  output logic                     RegWr,
  output logic [AW-1:0]            Rw,
  output logic [DW-1:0]            busW,
  output logic [31:0]              pend,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [AW-1:0] rd_q   [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] alu_slot;
  logic          mem_push;
  logic          alu_push;
  logic          pop;
  logic [31:0]   pend_c;

  // Readiness looks only at registered occupancy; a same-cycle pop never helps.
  assign mem_ready = (count < DEPTH_C);
  assign mem_push  = mem_valid & mem_ready & (mem_rd != '0);
  assign alu_ready = ((count + CW'(mem_push)) < DEPTH_C);
  assign alu_push  = alu_valid & alu_ready & (alu_rd != '0);
  assign pop       = (count != '0);
  assign alu_slot  = wr_ptr + PW'(mem_push);

  always_ff @(posedge Clk) begin
    if (mem_push) begin
      rd_q[wr_ptr]   <= mem_rd;
      data_q[wr_ptr] <= mem_data;
    end
    if (alu_push) begin
      rd_q[alu_slot]   <= alu_rd;
      data_q[alu_slot] <= alu_data;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      RegWr  <= 1'b0;
      Rw     <= '0;
      busW   <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(mem_push) + PW'(alu_push);
      count  <= count + CW'(mem_push) + CW'(alu_push) - CW'(pop);
      if (pop) begin
        RegWr  <= 1'b1;
        Rw     <= rd_q[rd_ptr];
        busW   <= data_q[rd_ptr];
        rd_ptr <= rd_ptr + PW'(1);
      end else begin
        RegWr  <= 1'b0;
      end
    end
  end

  // Pending covers every occupied slot plus the write currently on the port.
  always_comb begin
    pend_c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count) begin
        pend_c[rd_q[rd_ptr + PW'(i)]] = 1'b1;
      end
    end
    if (RegWr) begin
      pend_c[Rw] = 1'b1;
    end
    pend_c[0] = 1'b0;
  end

  assign pend = pend_c;

endmodule
`default_nettype wire
